// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared definitions for the PS/2 key sender: set-2 scan-code
//                constants, sequencing FSM state encoding and the
//                ASCII-to-set-2 lookup function.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    localparam logic [7:0] BREAK_CODE  = 8'hF0;
    localparam logic [7:0] LSHIFT_CODE = 8'h12;

    // Sequencing FSM encoding
    localparam int         ST_W      = 2;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOOKUP = 2'd1;
    localparam logic [1:0] ST_SEND   = 2'd2;
    localparam logic [1:0] ST_GAP    = 2'd3;

    typedef struct packed {
        logic       supported;
        logic       upper;      // needs a left-shift wrapper
        logic [7:0] code;       // set-2 make code
    } key_map_t;

    function automatic key_map_t ascii_to_set2(input logic [7:0] a);
        key_map_t   m;
        logic [7:0] lc;
        m  = '0;
        lc = a | 8'h20;         // folds 'A'-'Z' onto 'a'-'z'
        if (a >= 8'h30 && a <= 8'h39) begin
            m.supported = 1'b1;
            case (a[3:0])
                4'd0:    m.code = 8'h45;
                4'd1:    m.code = 8'h16;
                4'd2:    m.code = 8'h1E;
                4'd3:    m.code = 8'h26;
                4'd4:    m.code = 8'h25;
                4'd5:    m.code = 8'h2E;
                4'd6:    m.code = 8'h36;
                4'd7:    m.code = 8'h3D;
                4'd8:    m.code = 8'h3E;
                4'd9:    m.code = 8'h46;
                default: m.code = 8'h00;
            endcase
        end else if (lc >= 8'h61 && lc <= 8'h7A) begin
            m.supported = 1'b1;
            m.upper     = ~a[5];
            case (lc[4:0])
                5'd1:    m.code = 8'h1C;
                5'd2:    m.code = 8'h32;
                5'd3:    m.code = 8'h21;
                5'd4:    m.code = 8'h23;
                5'd5:    m.code = 8'h24;
                5'd6:    m.code = 8'h2B;
                5'd7:    m.code = 8'h34;
                5'd8:    m.code = 8'h33;
                5'd9:    m.code = 8'h43;
                5'd10:   m.code = 8'h3B;
                5'd11:   m.code = 8'h42;
                5'd12:   m.code = 8'h4B;
                5'd13:   m.code = 8'h3A;
                5'd14:   m.code = 8'h31;
                5'd15:   m.code = 8'h44;
                5'd16:   m.code = 8'h4D;
                5'd17:   m.code = 8'h15;
                5'd18:   m.code = 8'h2D;
                5'd19:   m.code = 8'h1B;
                5'd20:   m.code = 8'h2C;
                5'd21:   m.code = 8'h3C;
                5'd22:   m.code = 8'h2A;
                5'd23:   m.code = 8'h1D;
                5'd24:   m.code = 8'h22;
                5'd25:   m.code = 8'h35;
                5'd26:   m.code = 8'h1A;
                default: m.code = 8'h00;
            endcase
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_frame_tx
//  Description : Serialises one byte as an 11-bit PS/2 device frame
//                (start 0, data LSB first, odd parity, stop 1).
//  Ports       : clk, rst (async active-low)
//                i_load  - load i_byte and start a frame (only when idle)
//                i_byte  - byte to send
//                o_done  - high on the last clock of the stop bit
//                o_ps2_clk / o_ps2_data - PS/2 lines, idle high
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_frame_tx #(
    parameter int CLK_DIV = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_byte,
    output logic       o_done,
    output logic       o_ps2_clk,
    output logic       o_ps2_data
);

    localparam logic [9:0] c_HALF_LAST = 10'(CLK_DIV - 1);

    logic        r_active;
    logic        r_low;      // currently in the low half of the bit period
    logic [9:0]  r_cnt;
    logic [3:0]  r_bit;
    logic [10:0] r_shift;    // r_shift[0] is the bit on the line
    logic        r_clk;
    logic        r_data;
    logic        w_half_end;

    assign w_half_end = (r_cnt == c_HALF_LAST);
    assign o_done     = r_active & r_low & w_half_end & (r_bit == 4'd10);
    assign o_ps2_clk  = r_clk;
    assign o_ps2_data = r_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_active <= 1'b0;
            r_low    <= 1'b0;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_clk    <= 1'b1;
            r_data   <= 1'b1;
        end else if (i_load) begin
            // Start bit goes out immediately; clock stays high for one half
            r_active <= 1'b1;
            r_low    <= 1'b0;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift  <= {1'b1, ~^i_byte, i_byte, 1'b0};
            r_clk    <= 1'b1;
            r_data   <= 1'b0;
        end else if (r_active) begin
            if (!w_half_end) begin
                r_cnt <= r_cnt + 10'd1;
            end else begin
                r_cnt <= '0;
                if (!r_low) begin
                    r_low <= 1'b1;
                    r_clk <= 1'b0;
                end else begin
                    // New bit period: data changes together with ps2_clk rising
                    r_low <= 1'b0;
                    r_clk <= 1'b1;
                    if (r_bit == 4'd10) begin
                        r_active <= 1'b0;
                        r_bit    <= '0;
                        r_data   <= 1'b1;
                    end else begin
                        r_bit   <= r_bit + 4'd1;
                        r_shift <= {1'b1, r_shift[10:1]};
                        r_data  <= r_shift[1];
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_key_sender.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_sender
//  Description : Accepts ASCII key requests and emits the matching PS/2 set-2
//                make/break sequence, with an idle gap after every byte.
//  Ports       : clk, rst (async active-low)
//                key_valid/key_ascii/key_ready - request handshake
//                ps2_clk/ps2_data - device-driven PS/2 lines
//                busy    - sequence in progress
//                key_err - one-cycle pulse for an unsupported code
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_sender
    import ps2_pkg::*;
#(
    parameter int CLK_DIV    = 50,
    parameter int GAP_CYCLES = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [7:0] key_ascii,
    output logic       key_ready,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic       key_err
);

    localparam logic [15:0] c_GAP_LAST = 16'(GAP_CYCLES - 1);

    logic [ST_W-1:0] r_state;
    logic [ST_W-1:0] w_next;
    logic [7:0]      r_ascii;
    logic [2:0]      r_idx;      // index of the next byte to load
    logic [15:0]     r_gap_cnt;
    key_map_t        w_map;
    logic [2:0]      w_len;
    logic [7:0]      w_byte;
    logic            w_load;
    logic            w_done;
    logic            w_gap_end;
    logic            w_more;

    assign w_map     = ascii_to_set2(r_ascii);
    assign w_len     = w_map.upper ? 3'd6 : 3'd3;
    assign w_gap_end = (r_gap_cnt == c_GAP_LAST);
    assign w_more    = (r_idx != w_len);

    // Byte selected by the sequence index
    always_comb begin
        w_byte = w_map.code;
        if (w_map.upper) begin
            case (r_idx)
                3'd0:       w_byte = LSHIFT_CODE;
                3'd1, 3'd3: w_byte = w_map.code;
                3'd2, 3'd4: w_byte = BREAK_CODE;
                default:    w_byte = LSHIFT_CODE;
            endcase
        end else begin
            case (r_idx)
                3'd1:    w_byte = BREAK_CODE;
                default: w_byte = w_map.code;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (key_valid) w_next = ST_LOOKUP;
            ST_LOOKUP: w_next = w_map.supported ? ST_SEND : ST_IDLE;
            ST_SEND:   if (w_done) w_next = ST_GAP;
            ST_GAP:    if (w_gap_end) w_next = w_more ? ST_SEND : ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy      = (r_state != ST_IDLE);
        key_ready = (r_state == ST_IDLE);
        key_err   = (r_state == ST_LOOKUP) && !w_map.supported;
        w_load    = ((r_state == ST_LOOKUP) && w_map.supported) ||
                    ((r_state == ST_GAP) && w_gap_end && w_more);
    end

    // Request capture, sequence index and gap counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ascii   <= '0;
            r_idx     <= '0;
            r_gap_cnt <= '0;
        end else begin
            if ((r_state == ST_IDLE) && key_valid) begin
                r_ascii <= key_ascii;
                r_idx   <= '0;
            end
            if (w_load) begin
                r_idx <= r_idx + 3'd1;
            end
            if ((r_state == ST_GAP) && !w_gap_end) begin
                r_gap_cnt <= r_gap_cnt + 16'd1;
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

    ps2_frame_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_frame_tx (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_byte     (w_byte),
        .o_done     (w_done),
        .o_ps2_clk  (ps2_clk),
        .o_ps2_data (ps2_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_sender.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_key_sender
//  Description : Self-checking bench for ps2_key_sender. A line monitor
//                decodes PS/2 frames on ps2_clk falling edges and measures
//                phase and gap lengths; expected byte sequences come from a
//                table-driven model of the key mapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_sender;

    localparam int CLK_DIV    = 4;
    localparam int GAP_CYCLES = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [7:0] key_ascii;
    logic       key_ready;
    logic       ps2_clk;
    logic       ps2_data;
    logic       busy;
    logic       key_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ps2_key_sender #(
        .CLK_DIV    (CLK_DIV),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_ascii (key_ascii),
        .key_ready (key_ready),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .busy      (busy),
        .key_err   (key_err)
    );

    // ---------------- reference model ----------------
    logic [7:0] digit_tbl [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                   8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] letter_tbl [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B,
                                    8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B,
                                    8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                    8'h35, 8'h1A};
    logic [7:0] exp_q [$];

    task automatic build_exp(input logic [7:0] a, output bit sup);
        int         ai;
        logic [7:0] code;
        ai = int'(a);
        exp_q.delete();
        sup = 1'b1;
        if (ai >= 48 && ai <= 57) begin
            code = digit_tbl[ai - 48];
            exp_q = '{code, 8'hF0, code};
        end else if (ai >= 97 && ai <= 122) begin
            code = letter_tbl[ai - 97];
            exp_q = '{code, 8'hF0, code};
        end else if (ai >= 65 && ai <= 90) begin
            code = letter_tbl[ai - 65];
            exp_q = '{8'h12, code, 8'hF0, code, 8'hF0, 8'h12};
        end else begin
            sup = 1'b0;
        end
    endtask

    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        logic p;
        p = (($countones(b) % 2) == 0);
        return {1'b1, p, b, 1'b0};
    endfunction

    // ---------------- line monitor ----------------
    logic [10:0] q_frames [$];
    int          q_gap [$];
    int          q_hi [$];
    int          q_lo [$];
    logic [10:0] m_fr;
    int          bitpos, hi, lo, gcnt;
    bit          hi_on, counting;
    logic        prev_c, prev_d, m_c, m_d;
    int          err_pulses, lines_low, busy_cnt, dchg_low;

    initial begin
        bitpos = 0; prev_c = 1'b1; prev_d = 1'b1; hi_on = 0; counting = 0;
        hi = 0; lo = 0; gcnt = 0; m_fr = '0;
        err_pulses = 0; lines_low = 0; busy_cnt = 0; dchg_low = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                bitpos = 0; prev_c = 1'b1; prev_d = 1'b1;
                hi_on = 0; counting = 0;
            end else begin
                m_c = ps2_clk;
                m_d = ps2_data;
                if (key_err) err_pulses++;
                if (busy) busy_cnt++;
                if (!m_c || !m_d) lines_low++;
                if (!m_c && !prev_c && (m_d != prev_d)) dchg_low++;
                if (counting) begin
                    if (!m_d || !busy) begin
                        q_gap.push_back(gcnt);
                        counting = 0;
                    end else begin
                        gcnt++;
                    end
                end
                if (prev_c && !m_c) begin
                    if (hi_on) q_hi.push_back(hi);
                    hi_on = 0;
                    lo = 1;
                    m_fr[bitpos] = m_d;
                    bitpos++;
                    if (bitpos == 11) begin
                        q_frames.push_back(m_fr);
                        bitpos = 0;
                    end
                end else if (!prev_c && m_c) begin
                    q_lo.push_back(lo);
                    if (bitpos == 0) begin
                        counting = 1; gcnt = 1; hi_on = 0;
                    end else begin
                        hi_on = 1; hi = 1;
                    end
                end else if (m_c) begin
                    if (bitpos == 0 && prev_d && !m_d) begin
                        hi_on = 1; hi = 1;
                    end else if (hi_on) begin
                        hi++;
                    end
                end else begin
                    lo++;
                end
                prev_c = m_c;
                prev_d = m_d;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        q_frames.delete(); q_gap.delete(); q_hi.delete(); q_lo.delete();
        err_pulses = 0; lines_low = 0; busy_cnt = 0; dchg_low = 0;
    endtask

    task automatic send_key(input logic [7:0] a);
        int n;
        n = 0;
        while (!key_ready && n < 3000) begin
            tick();
            n++;
        end
        key_valid = 1'b1;
        key_ascii = a;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            tick();
            n++;
        end
        chk({tag, " idle_timeout"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic verify_seq(input string tag, input bit sup);
        int n, bad;
        n = exp_q.size();
        chk({tag, " frame_count"}, q_frames.size(), n);
        for (int i = 0; i < n && i < q_frames.size(); i++)
            chk($sformatf("%s frame%0d", tag, i), {21'd0, q_frames[i]},
                {21'd0, exp_frame(exp_q[i])});
        chk({tag, " gap_count"}, q_gap.size(), n);
        bad = 0;
        foreach (q_gap[i]) if (q_gap[i] != GAP_CYCLES) bad++;
        chk({tag, " gap_len_bad"}, bad, 0);
        bad = 0;
        foreach (q_hi[i]) if (q_hi[i] != CLK_DIV) bad++;
        foreach (q_lo[i]) if (q_lo[i] != CLK_DIV) bad++;
        chk({tag, " phase_len_bad"}, bad, 0);
        chk({tag, " fall_edges"}, q_lo.size(), 11 * n);
        chk({tag, " busy_cycles"}, busy_cnt, 1 + n * (22 * CLK_DIV + GAP_CYCLES));
        chk({tag, " key_err_pulses"}, err_pulses, sup ? 0 : 1);
        chk({tag, " data_change_low"}, dchg_low, 0);
        chk({tag, " ready_after"}, {31'd0, key_ready}, 32'd1);
        if (n == 0) chk({tag, " lines_low"}, lines_low, 0);
    endtask

    task automatic run_key(input logic [7:0] a, input string tag);
        bit sup;
        build_exp(a, sup);
        clear_mon();
        send_key(a);
        wait_idle(tag);
        verify_seq(tag, sup);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        bit         sup;
        int         n;
        logic [7:0] a;

        rst = 1'b0; key_valid = 1'b0; key_ascii = 8'h00;
        repeat (3) tick();
        chk("reset ps2_clk",   {31'd0, ps2_clk},   32'd1);
        chk("reset ps2_data",  {31'd0, ps2_data},  32'd1);
        chk("reset busy",      {31'd0, busy},      32'd0);
        chk("reset key_err",   {31'd0, key_err},   32'd0);
        chk("reset key_ready", {31'd0, key_ready}, 32'd1);
        rst = 1'b1;
        repeat (2) tick();

        run_key(8'h61, "a");
        run_key(8'h41, "A");

        run_key(8'h30, "zero");
        if (q_frames.size() > 0) begin
            chk("zero data_bits", {24'd0, q_frames[0][8:1]}, 32'h45);
            chk("zero parity",    {31'd0, q_frames[0][9]},   32'd0);
        end

        // Unsupported code
        build_exp(8'h23, sup);
        clear_mon();
        send_key(8'h23);
        n = 0;
        while (!key_ready && n < 10) begin
            tick();
            n++;
        end
        chk("hash ready_within_3", {31'd0, (n <= 3)}, 32'd1);
        wait_idle("hash");
        verify_seq("hash", sup);

        // Request while busy is ignored
        build_exp(8'h7A, sup);
        clear_mon();
        send_key(8'h7A);
        repeat (20) tick();
        key_valid = 1'b1;
        key_ascii = 8'h62;
        repeat (40) tick();
        key_valid = 1'b0;
        wait_idle("z_vs_b");
        verify_seq("z_vs_b", sup);

        // Reset in the middle of the first frame
        clear_mon();
        send_key(8'h71);
        n = 0;
        while (bitpos != 5 && n < 500) begin
            tick();
            n++;
        end
        chk("rst reached_bit5", bitpos, 5);
        #2;
        rst = 1'b0;
        #1;
        chk("rst ps2_clk",   {31'd0, ps2_clk},   32'd1);
        chk("rst ps2_data",  {31'd0, ps2_data},  32'd1);
        chk("rst busy",      {31'd0, busy},      32'd0);
        chk("rst key_ready", {31'd0, key_ready}, 32'd1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        run_key(8'h63, "after_rst_c");

        // Randomised keys
        for (int k = 0; k < 12; k++) begin
            case ($urandom_range(0, 3))
                0: a = 8'(48 + $urandom_range(0, 9));
                1: a = 8'(97 + $urandom_range(0, 25));
                2: a = 8'(65 + $urandom_range(0, 25));
                default: begin
                    do begin
                        a = 8'($urandom_range(0, 255));
                        build_exp(a, sup);
                    end while (sup);
                end
            endcase
            run_key(a, $sformatf("rand%0d_%02h", k, a));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
